// File: rtl/score_ram_responder.sv
// Score word RAM: power-up sweep to INIT_VALUE, then 2-stage reads and edge-triggered writes.
// Optional even-parity protection with sticky error flag: SCORE_RAM_PARITY_EN.
module score_ram_responder #(
   parameter int         DEPTH      = 64,
   parameter logic [3:0] INIT_VALUE = 4'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] scoreAddress,
   input  logic [3:0] ramDataIn,
   input  logic       readWrite,
   output logic [3:0] ramDataOut,
   output logic       ready
`ifdef SCORE_RAM_PARITY_EN
   ,
   output logic       parityErr
`endif
);

   localparam int AW = $clog2(DEPTH);
`ifdef SCORE_RAM_PARITY_EN
   localparam int MW = 5;
`else
   localparam int MW = 4;
`endif

   typedef enum logic {
      INIT,
      SERVE
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [5:0]      sweep_ptr;
   logic [5:0]      sweep_nx;
   logic [5:0]      addr_q;
   logic            rw_prev;
   logic            we;
   logic            we_g;
   logic [AW-1:0]   wr_addr;
   logic [3:0]      wr_data;
   logic [MW-1:0]   wr_word;
   logic [MW-1:0]   rd_word;
   logic            wr_ok;
   logic            rd_ok;
   logic [MW-1:0]   mem [DEPTH];

   assign wr_ok   = 32'(scoreAddress) < 32'(DEPTH);
   assign rd_ok   = 32'(addr_q) < 32'(DEPTH);
   assign rd_word = mem[addr_q[AW-1:0]];
   // A clock edge seen while reset is held must never commit a write.
   assign we_g    = we & rst;

`ifdef SCORE_RAM_PARITY_EN
   assign wr_word = {^wr_data, wr_data};
`else
   assign wr_word = wr_data;
`endif

   always_comb begin
      state_nx = state;
      sweep_nx = sweep_ptr;
      we       = 1'b0;
      wr_addr  = scoreAddress[AW-1:0];
      wr_data  = ramDataIn;
      unique case (state)
         INIT: begin
            we      = 1'b1;
            wr_addr = sweep_ptr[AW-1:0];
            wr_data = INIT_VALUE;
            if (sweep_ptr == 6'(DEPTH - 1)) begin
               state_nx = SERVE;
            end else begin
               sweep_nx = sweep_ptr + 6'd1;
            end
         end
         SERVE: begin
            we = readWrite & ~rw_prev & wr_ok;
         end
         default: begin
            state_nx = INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= INIT;
         sweep_ptr  <= 6'd0;
         ready      <= 1'b0;
         ramDataOut <= INIT_VALUE;
         addr_q     <= 6'd0;
         rw_prev    <= 1'b0;
      end else begin
         state     <= state_nx;
         sweep_ptr <= sweep_nx;
         ready     <= (state_nx == SERVE);
         addr_q    <= scoreAddress;
         rw_prev   <= readWrite;
         if (state == SERVE && rd_ok) begin
            ramDataOut <= rd_word[3:0];
         end else begin
            ramDataOut <= INIT_VALUE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we_g) begin
         mem[wr_addr] <= wr_word;
      end
   end

`ifdef SCORE_RAM_PARITY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         parityErr <= 1'b0;
      end else if (state == SERVE && rd_ok && (^rd_word)) begin
         parityErr <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_score_ram_responder.sv
// Directed bench for score_ram_responder: sweep timing, read latency, edge writes, reset.
module tb_score_ram_responder;

   logic       clk;
   logic       rst;
   logic [5:0] scoreAddress;
   logic [3:0] ramDataIn;
   logic       readWrite;
   logic [3:0] ramDataOut;
   logic       ready;
`ifdef SCORE_RAM_PARITY_EN
   logic       parityErr;
`endif

   int checks = 0;
   int errors = 0;

   score_ram_responder dut (
      .clk          (clk),
      .rst          (rst),
      .scoreAddress (scoreAddress),
      .ramDataIn    (ramDataIn),
      .readWrite    (readWrite),
      .ramDataOut   (ramDataOut),
      .ready        (ready)
`ifdef SCORE_RAM_PARITY_EN
      ,
      .parityErr    (parityErr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [5:0] a, input logic [3:0] d);
      scoreAddress = a;
      ramDataIn    = d;
      readWrite    = 1'b1;
      step(1);
      readWrite = 1'b0;
      step(1);
   endtask

   task automatic do_read(input logic [5:0] a, output logic [3:0] d);
      scoreAddress = a;
      readWrite    = 1'b0;
      step(2);
      d = ramDataOut;
   endtask

   task automatic test_reset;
      rst          = 1'b0;
      scoreAddress = 6'd0;
      ramDataIn    = 4'd0;
      readWrite    = 1'b0;
      step(3);
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready got %b want 0", ready);
      end
      checks++;
      if (ramDataOut !== 4'd0) begin
         errors++;
         $display("FAIL reset_dout got %h want 0", ramDataOut);
      end
   endtask

   task automatic test_init_sweep;
      logic [3:0] d;
      logic       exp;
      rst = 1'b1;
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL sweep_cycle0 ready got %b want 0", ready);
      end
      for (int c = 1; c <= 64; c++) begin
         step(1);
         exp = (c == 64);
         checks++;
         if (ready !== exp) begin
            errors++;
            $display("FAIL sweep_ready cycle %0d got %b want %b", c, ready, exp);
         end
         if (c < 64) begin
            checks++;
            if (ramDataOut !== 4'd0) begin
               errors++;
               $display("FAIL sweep_dout cycle %0d got %h want 0", c, ramDataOut);
            end
         end
      end
      for (int a = 0; a < 64; a++) begin
         do_read(6'(a), d);
         checks++;
         if (d !== 4'd0) begin
            errors++;
            $display("FAIL sweep_read addr %0d got %h want 0", a, d);
         end
      end
   endtask

   task automatic test_write_read;
      logic [3:0] d;
      do_write(6'd12, 4'd7);
      do_read(6'd0, d);
      scoreAddress = 6'd12;
      step(1);
      checks++;
      if (ramDataOut !== 4'd0) begin
         errors++;
         $display("FAIL latency_1cyc got %h want 0", ramDataOut);
      end
      step(1);
      checks++;
      if (ramDataOut !== 4'd7) begin
         errors++;
         $display("FAIL write_read_12 got %h want 7", ramDataOut);
      end
   endtask

   task automatic test_hold_write;
      logic [3:0] d;
      logic [3:0] seq [5];
      seq = '{4'd2, 4'd5, 4'd9, 4'd9, 4'd9};
      scoreAddress = 6'd3;
      readWrite    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ramDataIn = seq[i];
         step(1);
      end
      readWrite = 1'b0;
      step(1);
      do_read(6'd3, d);
      checks++;
      if (d !== 4'd2) begin
         errors++;
         $display("FAIL hold_write_3 got %h want 2", d);
      end
   endtask

   task automatic test_globals;
      logic [3:0] d;
      do_write(6'd40, 4'd9);
      do_write(6'd41, 4'd3);
      do_read(6'd40, d);
      checks++;
      if (d !== 4'd9) begin
         errors++;
         $display("FAIL global_40 got %h want 9", d);
      end
      do_read(6'd41, d);
      checks++;
      if (d !== 4'd3) begin
         errors++;
         $display("FAIL global_41 got %h want 3", d);
      end
   endtask

   task automatic test_read_during_write;
      logic [3:0] d;
      do_read(6'd12, d);
      ramDataIn = 4'hC;
      readWrite = 1'b1;
      step(1);
      checks++;
      if (ramDataOut !== 4'd7) begin
         errors++;
         $display("FAIL rdw_old got %h want 7", ramDataOut);
      end
      readWrite = 1'b0;
      step(2);
      checks++;
      if (ramDataOut !== 4'hC) begin
         errors++;
         $display("FAIL rdw_new got %h want c", ramDataOut);
      end
   endtask

   task automatic test_back_to_back;
      logic [5:0] adr [5];
      logic [3:0] exp [5];
      adr = '{6'd40, 6'd41, 6'd3, 6'd12, 6'd0};
      exp = '{4'd9, 4'd3, 4'd2, 4'hC, 4'd0};
      readWrite = 1'b0;
      for (int i = 0; i < 5; i++) begin
         scoreAddress = adr[i];
         step(1);
         if (i >= 1) begin
            checks++;
            if (ramDataOut !== exp[i-1]) begin
               errors++;
               $display("FAIL b2b idx %0d got %h want %h", i - 1, ramDataOut, exp[i-1]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_sweep;
      logic [3:0] d;
      logic       exp;
      do_write(6'd5, 4'd4);
      do_read(6'd5, d);
      checks++;
      if (d !== 4'd4) begin
         errors++;
         $display("FAIL pre_reset_5 got %h want 4", d);
      end
      rst = 1'b0;
      step(2);
      rst = 1'b1;
      step(30);
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_sweep_ready got %b want 0", ready);
      end
      rst = 1'b0;
      step(2);
      rst = 1'b1;
      for (int c = 1; c <= 64; c++) begin
         scoreAddress = 6'd5;
         ramDataIn    = 4'd6;
         readWrite    = c[0];
         step(1);
         exp = (c == 64);
         checks++;
         if (ready !== exp) begin
            errors++;
            $display("FAIL resweep_ready cycle %0d got %b want %b", c, ready, exp);
         end
      end
      readWrite = 1'b0;
      step(1);
      do_read(6'd5, d);
      checks++;
      if (d !== 4'd0) begin
         errors++;
         $display("FAIL init_write_5 got %h want 0", d);
      end
   endtask

   task automatic test_init_end_edge;
      logic [3:0] d;
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      readWrite = 1'b0;
      step(63);
      scoreAddress = 6'd20;
      ramDataIn    = 4'hF;
      readWrite    = 1'b1;
      step(1);
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL edge_end_ready got %b want 1", ready);
      end
      step(3);
      readWrite = 1'b0;
      step(1);
      do_read(6'd20, d);
      checks++;
      if (d !== 4'd0) begin
         errors++;
         $display("FAIL edge_end_20 got %h want 0", d);
      end
   endtask

`ifdef SCORE_RAM_PARITY_EN
   task automatic test_parity;
      logic [3:0] d;
      do_write(6'd8, 4'd5);
      do_read(6'd8, d);
      checks++;
      if (parityErr !== 1'b0) begin
         errors++;
         $display("FAIL parity_clean got %b want 0", parityErr);
      end
      dut.mem[8][0] = ~dut.mem[8][0];
      do_read(6'd8, d);
      checks++;
      if (parityErr !== 1'b1) begin
         errors++;
         $display("FAIL parity_set got %b want 1", parityErr);
      end
      do_read(6'd0, d);
      checks++;
      if (parityErr !== 1'b1) begin
         errors++;
         $display("FAIL parity_sticky got %b want 1", parityErr);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (parityErr !== 1'b0) begin
         errors++;
         $display("FAIL parity_reset got %b want 0", parityErr);
      end
      rst = 1'b1;
      step(66);
   endtask
`endif

   task automatic test_async_reset;
      logic [3:0] d;
      do_write(6'd30, 4'd6);
      do_read(6'd30, d);
      checks++;
      if (d !== 4'd6) begin
         errors++;
         $display("FAIL async_pre got %h want 6", d);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL async_ready got %b want 0", ready);
      end
      checks++;
      if (ramDataOut !== 4'd0) begin
         errors++;
         $display("FAIL async_dout got %h want 0", ramDataOut);
      end
      step(1);
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_init_sweep();
      test_write_read();
      test_hold_write();
      test_globals();
      test_read_during_write();
      test_back_to_back();
      test_reset_mid_sweep();
      test_init_end_edge();
`ifdef SCORE_RAM_PARITY_EN
      test_parity();
`endif
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/score_ram_responder.md
SCORE_RAM_RESPONDER -- requirements
Module: score_ram_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 4-bit score words, addressed 0..DEPTH-1.
REQ-002 SHALL have parameter INIT_VALUE, default 4'd0, the value written to every word during the init sweep.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port scoreAddress  input  6  word address from the score initiator.
REQ-006 SHALL have port ramDataIn  input  4  write data.
REQ-007 SHALL have port readWrite  input  1  write request, 1 = write, 0 = read.
REQ-008 SHALL have port ramDataOut  output  4  read data.
REQ-009 SHALL have port ready  output  1  high once the init sweep completes.
REQ-010 SHALL have port parityErr  output  1  sticky parity error flag; present only with SCORE_RAM_PARITY_EN.

Function
REQ-011 SHALL implement a 2-state FSM: INIT (entered on reset) and SERVE.
REQ-012 INIT: SHALL write INIT_VALUE to word sweepPtr each cycle, sweepPtr counting 0..DEPTH-1; after writing DEPTH-1 it SHALL enter SERVE and set ready=1, so ready rises exactly DEPTH cycles after reset release.
REQ-013 INIT: SHALL ignore external writes; ramDataOut SHALL stay INIT_VALUE.
REQ-014 SERVE reads: SHALL register scoreAddress (stage 1), then drive ramDataOut from mem[registered address] (stage 2); latency is 2 cycles from address change to valid data.
REQ-015 Addresses >= DEPTH SHALL read INIT_VALUE and SHALL NOT be written.
REQ-016 SERVE writes: SHALL write ramDataIn to mem[scoreAddress] only on the cycle a 0->1 transition of readWrite is detected (registered previous value); holding readWrite high SHALL produce exactly one write.
REQ-017 A read of the address being written in the same cycle SHALL return the old value; the new value SHALL be visible 2 cycles after the write cycle.
REQ-018 Address 40/41 (global high 10s/1s) SHALL receive no special treatment.
REQ-019 A readWrite rising edge present in the same cycle INIT ends SHALL be ignored; the edge detector SHALL still track readWrite during INIT.

Reset
REQ-020 On rst=0, asynchronously: state=INIT, sweepPtr=0, ready=0, ramDataOut=INIT_VALUE, address register=0, previous readWrite=0, parityErr=0.
REQ-021 Reset asserted mid-operation (INIT or SERVE) SHALL abort any write and restart the full sweep; memory contents need not be cleared asynchronously.

Configuration
REQ-022 With SCORE_RAM_PARITY_EN defined: each word SHALL store an extra even-parity bit; a stage-2 read with mismatched parity SHALL set parityErr, which stays 1 until reset; the sweep SHALL write correct parity.
REQ-023 Without SCORE_RAM_PARITY_EN: no parity storage, no parityErr port; all other behaviour identical.

Verification
REQ-024 Release reset, hold readWrite=0 -> ready=0 for cycles 0..63, ready=1 at cycle 64; read of all 64 addresses returns 0.
REQ-025 In SERVE, address 12, data 7, one-cycle readWrite pulse, then readWrite=0 -> read of address 12 returns 7 two cycles after the address is applied.
REQ-026 Hold readWrite high 5 cycles at address 3 while ramDataIn changes 2,5,9 -> word 3 holds 2 (single write on rising edge).
REQ-027 Write 9 to address 40, then 3 to address 41, then read 40 and 41 -> 9 and 3 respectively after 2-cycle latency each.
REQ-028 Assert rst at sweep count 30, release -> ready stays 0 for a full 64 cycles; writes during INIT (address 5, data 6) leave word 5 = 0.
REQ-029 With SCORE_RAM_PARITY_EN, force-flip a stored bit at address 8 and read it -> parityErr=1 two cycles later and remains 1 until reset.
